// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types for the memory arbiter
package arb_pkg;

    // FREE: round-robin arbitration each cycle.
    // LOCKED: the owner keeps the memory until it releases or is forced off.
    typedef enum logic [0:0] {
        ARB_FREE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker
// Ports:
//   req  - request vector, one bit per requester
//   ptr  - index where the search starts (highest priority this cycle)
//   gnt  - one-hot grant, zero when no request is set
//   idx  - index of the granted requester (0 when gnt is zero)
module rr_pick #(
    parameter int N     = 2,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx
);

    logic [IDX_W:0] cand;

    always_comb begin
        gnt  = '0;
        idx  = '0;
        cand = '0;
        // Walk offsets from farthest to nearest so the nearest hit wins.
        for (int i = N - 1; i >= 0; i--) begin
            cand = {1'b0, ptr} + (IDX_W + 1)'(i);
            if (cand >= (IDX_W + 1)'(N)) begin
                cand = cand - (IDX_W + 1)'(N);
            end
            if (req[cand[IDX_W-1:0]]) begin
                gnt                   = '0;
                gnt[cand[IDX_W-1:0]]  = 1'b1;
                idx                   = cand[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/mem_arb.sv
// rtl/mem_arb.sv - single-cycle memory arbiter with bounded lock
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   i_req/i_lock/i_we        - per-requester request, keep-grant, write enable
//   i_addr/i_wdata           - per-requester address and store data
//   o_gnt                    - one-hot-or-zero grant
//   o_rdata                  - load data for the granted requester
//   o_locked                 - high while a lock is held
//   o_mem_we/addr/wdata      - memory-side access
//   i_mem_rdata              - combinational memory read data at o_mem_addr
module mem_arb
    import arb_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 3,
    parameter int MAX_LOCK   = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_REQ-1:0]                  i_req,
    input  logic [NUM_REQ-1:0]                  i_lock,
    input  logic [NUM_REQ-1:0]                  i_we,
    input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]  i_addr,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  i_wdata,
    output logic [NUM_REQ-1:0]                  o_gnt,
    output logic [DATA_WIDTH-1:0]               o_rdata,
    output logic                                o_locked,
    output logic                                o_mem_we,
    output logic [ADDR_WIDTH-1:0]               o_mem_addr,
    output logic [DATA_WIDTH-1:0]               o_mem_wdata,
    input  logic [DATA_WIDTH-1:0]               i_mem_rdata
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_LOCK + 1);

    arb_state_e         state, state_n;
    logic [IDX_W-1:0]   ptr, ptr_n;
    logic [IDX_W-1:0]   owner, owner_n;
    logic [CNT_W-1:0]   lock_cnt, lock_cnt_n;

    logic [NUM_REQ-1:0] pick_gnt;
    logic [IDX_W-1:0]   pick_idx;
    logic [NUM_REQ-1:0] gnt;
    logic [IDX_W-1:0]   gnt_idx;
    logic [NUM_REQ-1:0] owner_mask;
    logic               others_req;
    logic               release_lock;

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] k);
        logic [IDX_W-1:0] r;
        if (k == IDX_W'(NUM_REQ - 1)) begin
            r = '0;
        end else begin
            r = k + 1'b1;
        end
        return r;
    endfunction

    rr_pick #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req (i_req),
        .ptr (ptr),
        .gnt (pick_gnt),
        .idx (pick_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ARB_FREE;
            ptr      <= '0;
            owner    <= '0;
            lock_cnt <= '0;
        end else begin
            state    <= state_n;
            ptr      <= ptr_n;
            owner    <= owner_n;
            lock_cnt <= lock_cnt_n;
        end
    end

    always_comb begin
        owner_mask        = '0;
        owner_mask[owner] = 1'b1;
        others_req        = |(i_req & ~owner_mask);
    end

    always_comb begin
        state_n      = state;
        ptr_n        = ptr;
        owner_n      = owner;
        lock_cnt_n   = lock_cnt;
        gnt          = '0;
        gnt_idx      = pick_idx;
        release_lock = 1'b0;

        if (!rst) begin
            unique case (state)
                ARB_FREE: begin
                    gnt     = pick_gnt;
                    gnt_idx = pick_idx;
                    if (|pick_gnt) begin
                        if (i_lock[pick_idx]) begin
                            state_n    = ARB_LOCKED;
                            owner_n    = pick_idx;
                            lock_cnt_n = CNT_W'(1);
                        end else begin
                            ptr_n = next_idx(pick_idx);
                        end
                    end
                end
                ARB_LOCKED: begin
                    gnt_idx = owner;
                    if (i_req[owner]) begin
                        gnt[owner] = 1'b1;
                        // Forced release only when the budget is spent and someone else waits.
                        if (i_lock[owner] &&
                            !((lock_cnt >= CNT_W'(MAX_LOCK - 1)) && others_req)) begin
                            if (lock_cnt < CNT_W'(MAX_LOCK)) begin
                                lock_cnt_n = lock_cnt + 1'b1;
                            end
                        end else begin
                            release_lock = 1'b1;
                        end
                    end else begin
                        release_lock = 1'b1;
                    end
                end
                default: begin
                    state_n = ARB_FREE;
                end
            endcase

            if (release_lock) begin
                state_n    = ARB_FREE;
                ptr_n      = next_idx(owner);
                lock_cnt_n = '0;
            end
        end
    end

    always_comb begin
        o_gnt       = gnt;
        o_mem_we    = 1'b0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        o_rdata     = '0;
        if (|gnt) begin
            o_mem_we    = i_we[gnt_idx];
            o_mem_addr  = i_addr[gnt_idx];
            o_mem_wdata = i_wdata[gnt_idx];
            o_rdata     = i_mem_rdata;
        end
    end

    assign o_locked = !rst && (state == ARB_LOCKED);

endmodule

// File: tb/tb_mem_arb.sv
// tb/tb_mem_arb.sv - self-checking bench for mem_arb
module tb_mem_arb;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       i_req;
    logic [1:0]       i_lock;
    logic [1:0]       i_we;
    logic [1:0][2:0]  i_addr;
    logic [1:0][31:0] i_wdata;
    logic [1:0]       o_gnt;
    logic [31:0]      o_rdata;
    logic             o_locked;
    logic             o_mem_we;
    logic [2:0]       o_mem_addr;
    logic [31:0]      o_mem_wdata;
    logic [31:0]      i_mem_rdata;

    logic [31:0] mem [8] = '{32'h100, 32'h101, 32'h102, 32'h103,
                             32'h104, 32'h105, 32'h106, 32'h107};

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (o_mem_we) mem[o_mem_addr] <= o_mem_wdata;
    end

    assign i_mem_rdata = mem[o_mem_addr];

    mem_arb #(
        .NUM_REQ    (2),
        .DATA_WIDTH (32),
        .ADDR_WIDTH (3),
        .MAX_LOCK   (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_req       (i_req),
        .i_lock      (i_lock),
        .i_we        (i_we),
        .i_addr      (i_addr),
        .i_wdata     (i_wdata),
        .o_gnt       (o_gnt),
        .o_rdata     (o_rdata),
        .o_locked    (o_locked),
        .o_mem_we    (o_mem_we),
        .o_mem_addr  (o_mem_addr),
        .o_mem_wdata (o_mem_wdata),
        .i_mem_rdata (i_mem_rdata)
    );

    typedef struct {
        logic [1:0]  gnt;
        logic        locked;
        logic        we;
        logic [2:0]  addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } exp_t;

    typedef struct {
        logic        rst;
        logic [1:0]  req;
        logic [1:0]  lock;
        logic [1:0]  we;
        logic [2:0]  a0;
        logic [2:0]  a1;
        logic [31:0] d0;
        logic [31:0] d1;
        exp_t        e;
    } vec_t;

    localparam logic [31:0] D0 = 32'h0000_00D0;
    localparam logic [31:0] D1 = 32'h0000_00D1;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    vec_t tbl[13];

    function automatic vec_t mk(input logic r, input logic [1:0] req, input logic [1:0] lock,
                                input logic [1:0] we, input logic [2:0] a0, input logic [2:0] a1,
                                input logic [31:0] d0, input logic [31:0] d1,
                                input logic [1:0] gnt, input logic locked, input logic mwe,
                                input logic [2:0] maddr, input logic [31:0] mwd,
                                input logic [31:0] rd);
        vec_t v;
        v.rst = r; v.req = req; v.lock = lock; v.we = we;
        v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1;
        v.e.gnt = gnt; v.e.locked = locked; v.e.we = mwe;
        v.e.addr = maddr; v.e.wdata = mwd; v.e.rdata = rd;
        return v;
    endfunction

    function automatic vec_t mk_rst();
        return mk(1'b1, 2'b11, 2'b11, 2'b11, 3'd5, 3'd6, D0, D1,
                  2'b00, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    endfunction

    task automatic chk(input string tag, input string field,
                       input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s %s: got %h expected %h", tag, field, act, req);
        end
    endtask

    task automatic apply(input string tag, input vec_t v);
        exp_t e;
        @(posedge clk);
        #1;
        rst     = v.rst;
        i_req   = v.req;
        i_lock  = v.lock;
        i_we    = v.we;
        i_addr  = {v.a1, v.a0};
        i_wdata = {v.d1, v.d0};
        exp_q.push_back(v.e);
        @(negedge clk);
        e = exp_q.pop_front();
        chk(tag, "gnt",    32'(o_gnt),       32'(e.gnt));
        chk(tag, "locked", 32'(o_locked),    32'(e.locked));
        chk(tag, "mem_we", 32'(o_mem_we),    32'(e.we));
        chk(tag, "addr",   32'(o_mem_addr),  32'(e.addr));
        chk(tag, "wdata",  o_mem_wdata,      e.wdata);
        chk(tag, "rdata",  o_rdata,          e.rdata);
    endtask

    initial begin
        rst = 1'b1; i_req = '0; i_lock = '0; i_we = '0; i_addr = '0; i_wdata = '0;

        tbl[0]  = mk_rst();
        tbl[1]  = mk_rst();
        tbl[2]  = mk(0, 2'b11, 2'b00, 2'b00, 3'd1, 3'd3, D0, D1, 2'b01, 0, 0, 3'd1, D0, 32'h101);
        tbl[3]  = mk(0, 2'b11, 2'b00, 2'b00, 3'd1, 3'd3, D0, D1, 2'b10, 0, 0, 3'd3, D1, 32'h103);
        tbl[4]  = mk(0, 2'b11, 2'b00, 2'b00, 3'd1, 3'd3, D0, D1, 2'b01, 0, 0, 3'd1, D0, 32'h101);
        tbl[5]  = mk(0, 2'b01, 2'b00, 2'b01, 3'd2, 3'd3, 32'd7, D1, 2'b01, 0, 1, 3'd2, 32'd7, 32'h102);
        tbl[6]  = mk(0, 2'b10, 2'b00, 2'b00, 3'd0, 3'd2, D0, 32'hAA, 2'b10, 0, 0, 3'd2, 32'hAA, 32'd7);
        tbl[7]  = mk(0, 2'b00, 2'b00, 2'b11, 3'd4, 3'd5, D0, D1, 2'b00, 0, 0, 3'd0, 32'd0, 32'd0);
        tbl[8]  = mk(0, 2'b10, 2'b00, 2'b00, 3'd1, 3'd3, D0, D1, 2'b10, 0, 0, 3'd3, D1, 32'h103);
        tbl[9]  = mk(0, 2'b11, 2'b00, 2'b00, 3'd1, 3'd3, D0, D1, 2'b01, 0, 0, 3'd1, D0, 32'h101);
        tbl[10] = mk(0, 2'b01, 2'b00, 2'b00, 3'd1, 3'd3, D0, D1, 2'b01, 0, 0, 3'd1, D0, 32'h101);
        tbl[11] = mk(0, 2'b11, 2'b00, 2'b00, 3'd1, 3'd3, D0, D1, 2'b10, 0, 0, 3'd3, D1, 32'h103);
        tbl[12] = mk(0, 2'b11, 2'b00, 2'b10, 3'd1, 3'd3, D0, D1, 2'b01, 0, 0, 3'd1, D0, 32'h101);

        for (int i = 0; i < 13; i++) apply($sformatf("tbl%0d", i), tbl[i]);

        // Contended lock: four owner cycles, then forced hand-over.
        apply("lockmax_rst", mk_rst());
        for (int c = 1; c <= 4; c++)
            apply($sformatf("lockmax_c%0d", c),
                  mk(0, 2'b11, 2'b01, 2'b00, 3'd4, 3'd6, D0, D1,
                     2'b01, logic'(c > 1), 0, 3'd4, D0, 32'h104));
        apply("lockmax_c5", mk(0, 2'b11, 2'b01, 2'b00, 3'd4, 3'd6, D0, D1,
                               2'b10, 0, 0, 3'd6, D1, 32'h106));

        // Uncontended lock holds indefinitely; saturated count still releases on contention.
        apply("lockidle_rst", mk_rst());
        for (int c = 1; c <= 10; c++)
            apply($sformatf("lockidle_c%0d", c),
                  mk(0, 2'b01, 2'b01, 2'b00, 3'd4, 3'd6, D0, D1,
                     2'b01, logic'(c > 1), 0, 3'd4, D0, 32'h104));
        apply("lockidle_c11", mk(0, 2'b11, 2'b01, 2'b00, 3'd4, 3'd6, D0, D1,
                                 2'b01, 1, 0, 3'd4, D0, 32'h104));
        apply("lockidle_c12", mk(0, 2'b11, 2'b01, 2'b00, 3'd4, 3'd6, D0, D1,
                                 2'b10, 0, 0, 3'd6, D1, 32'h106));

        // Owner 1 drops its request: no grant that cycle, then FREE with ptr 0.
        apply("drop_rst", mk_rst());
        apply("drop_c1", mk(0, 2'b10, 2'b10, 2'b00, 3'd4, 3'd6, D0, D1, 2'b10, 0, 0, 3'd6, D1, 32'h106));
        apply("drop_c2", mk(0, 2'b10, 2'b10, 2'b00, 3'd4, 3'd6, D0, D1, 2'b10, 1, 0, 3'd6, D1, 32'h106));
        apply("drop_c3", mk(0, 2'b01, 2'b00, 2'b00, 3'd4, 3'd6, D0, D1, 2'b00, 1, 0, 3'd0, 32'd0, 32'd0));
        apply("drop_c4", mk(0, 2'b11, 2'b00, 2'b00, 3'd4, 3'd6, D0, D1, 2'b01, 0, 0, 3'd4, D0, 32'h104));

        // Reset mid-lock with a pending store: no write lands in the reset cycle.
        apply("rstlock_rst", mk_rst());
        apply("rstlock_c1", mk(0, 2'b01, 2'b01, 2'b01, 3'd5, 3'd6, 32'h55, D1,
                               2'b01, 0, 1, 3'd5, 32'h55, 32'h105));
        apply("rstlock_c2", mk(0, 2'b01, 2'b01, 2'b01, 3'd5, 3'd6, 32'h55, D1,
                               2'b01, 1, 1, 3'd5, 32'h55, 32'h55));
        apply("rstlock_c3", mk(1, 2'b01, 2'b01, 2'b01, 3'd5, 3'd6, 32'h99, D1,
                               2'b00, 0, 0, 3'd0, 32'd0, 32'd0));
        apply("rstlock_c4", mk(0, 2'b11, 2'b00, 2'b00, 3'd5, 3'd6, 32'h99, D1,
                               2'b01, 0, 0, 3'd5, 32'h99, 32'h55));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
